// File: rtl/bram_rmw_pkg.sv
// Shared types, default widths and the read-modify-write merge helper for bram_rmw_ctrl.
// The merge helper works on a wide fixed vector; callers size-cast in and out.
package bram_rmw_pkg;

    localparam int BRAM_RMW_ADDR_W = 9;
    localparam int BRAM_RMW_DATA_W = 32;
    localparam int BRAM_RMW_MAX_W  = 1024;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } bram_rmw_state_e;

    // Bits with wem=1 come from the new data, the rest keep the stored word.
    function automatic logic [BRAM_RMW_MAX_W-1:0] bram_rmw_merge(
        input logic [BRAM_RMW_MAX_W-1:0] q,
        input logic [BRAM_RMW_MAX_W-1:0] d,
        input logic [BRAM_RMW_MAX_W-1:0] wem
    );
        return (q & ~wem) | (d & wem);
    endfunction

endpackage

// File: rtl/bram_rmw_ctrl.sv
// Single-port BRAM front end: reads, full writes and bit-masked writes via read-modify-write.
// Define BRAM_RMW_FULLMASK_FASTPATH_EN to retire all-ones-mask writes in one cycle.
module bram_rmw_ctrl
    import bram_rmw_pkg::*;
#(
    parameter int ADDR_W = BRAM_RMW_ADDR_W,
    parameter int DATA_W = BRAM_RMW_DATA_W
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WE,
    input  logic [ADDR_W-1:0] REQ_A,
    input  logic [DATA_W-1:0] REQ_D,
    input  logic [DATA_W-1:0] REQ_WEM,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_Q,
    output logic              MEM_CE,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_A,
    output logic [DATA_W-1:0] MEM_D,
    input  logic [DATA_W-1:0] MEM_Q
);

    bram_rmw_state_e   r_state;
    logic [ADDR_W-1:0] r_a;
    logic [DATA_W-1:0] r_d;
    logic [DATA_W-1:0] r_wem;
    logic              r_rsp_vld;

    logic              w_accept;
    logic              w_mask_full;
    logic              w_rd;
    logic              w_wr_full;
    logic              w_wr_rmw;
    logic [DATA_W-1:0] w_merged;

    assign REQ_READY = (r_state == ST_IDLE);
    // Gating with RSTN keeps the BRAM port quiet for the whole reset window.
    assign w_accept  = REQ_VALID & REQ_READY & RSTN;

`ifdef BRAM_RMW_FULLMASK_FASTPATH_EN
    assign w_mask_full = &REQ_WEM;
`else
    assign w_mask_full = 1'b0;
`endif

    assign w_rd      = w_accept & ~REQ_WE;
    assign w_wr_full = w_accept & REQ_WE & w_mask_full;
    assign w_wr_rmw  = w_accept & REQ_WE & (|REQ_WEM) & ~w_mask_full;

    assign w_merged  = DATA_W'(bram_rmw_merge(BRAM_RMW_MAX_W'(MEM_Q),
                                              BRAM_RMW_MAX_W'(r_d),
                                              BRAM_RMW_MAX_W'(r_wem)));

    assign RSP_VALID = r_rsp_vld;
    assign RSP_Q     = MEM_Q;

    // Zero-mask writes fall through every branch and never touch the BRAM.
    always_comb begin
        MEM_CE = 1'b0;
        MEM_WE = 1'b0;
        MEM_A  = '0;
        MEM_D  = '0;
        if (r_state == ST_MERGE) begin
            MEM_CE = 1'b1;
            MEM_WE = 1'b1;
            MEM_A  = r_a;
            MEM_D  = w_merged;
        end else if (w_rd || w_wr_rmw) begin
            MEM_CE = 1'b1;
            MEM_A  = REQ_A;
        end else if (w_wr_full) begin
            MEM_CE = 1'b1;
            MEM_WE = 1'b1;
            MEM_A  = REQ_A;
            MEM_D  = REQ_D;
        end
    end

    // Reset in MERGE drops the latched write before its write cycle can occur.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_d       <= '0;
            r_wem     <= '0;
            r_rsp_vld <= 1'b0;
        end else begin
            r_rsp_vld <= w_rd;
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_rmw) begin
                        r_state <= ST_MERGE;
                        r_a     <= REQ_A;
                        r_d     <= REQ_D;
                        r_wem   <= REQ_WEM;
                    end
                end
                ST_MERGE: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_rmw_ctrl.sv
// Bench for bram_rmw_ctrl: BRAM behavioural model, transaction-level golden memory,
// per-cycle compare process, directed literal scenarios, then randomized traffic.
module tb_bram_rmw_ctrl;

    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int DEPTH = 512;
`ifdef BRAM_RMW_FULLMASK_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          REQ_VALID = 1'b0;
    logic          REQ_READY;
    logic          REQ_WE = 1'b0;
    logic [AW-1:0] REQ_A = '0;
    logic [DW-1:0] REQ_D = '0;
    logic [DW-1:0] REQ_WEM = '0;
    logic          RSP_VALID;
    logic [DW-1:0] RSP_Q;
    logic          MEM_CE;
    logic          MEM_WE;
    logic [AW-1:0] MEM_A;
    logic [DW-1:0] MEM_D;
    logic [DW-1:0] MEM_Q;

    bram_rmw_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_A(REQ_A), .REQ_D(REQ_D), .REQ_WEM(REQ_WEM),
        .RSP_VALID(RSP_VALID), .RSP_Q(RSP_Q),
        .MEM_CE(MEM_CE), .MEM_WE(MEM_WE), .MEM_A(MEM_A), .MEM_D(MEM_D), .MEM_Q(MEM_Q)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // BRAM_512x32 stand-in: synchronous read, write on CE&WE.
    logic [DW-1:0] bmem [DEPTH];
    logic [DW-1:0] bq = '0;
    assign MEM_Q = bq;
    always @(posedge CLK) begin
        if (MEM_CE) begin
            if (MEM_WE) bmem[MEM_A] = MEM_D;
            else        bq <= bmem[MEM_A];
        end
    end

    // Golden memory: transactions applied in acceptance order; a masked write
    // commits only when its second cycle completes without reset.
    logic [DW-1:0] gold [DEPTH];
    bit            m_ready = 1'b1;
    bit            m_rsp_vld = 1'b0;
    logic [DW-1:0] m_rsp_q = '0;
    bit            m_merge = 1'b0;
    logic [AW-1:0] m_a = '0;
    logic [DW-1:0] m_d = '0;
    logic [DW-1:0] m_wem = '0;

    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            m_ready   = 1'b1;
            m_rsp_vld = 1'b0;
            m_merge   = 1'b0;
        end else if (m_merge) begin
            gold[m_a] = (gold[m_a] & ~m_wem) | (m_d & m_wem);
            m_merge   = 1'b0;
            m_ready   = 1'b1;
            m_rsp_vld = 1'b0;
        end else begin
            m_rsp_vld = 1'b0;
            if (REQ_VALID) begin
                if (!REQ_WE) begin
                    m_rsp_vld = 1'b1;
                    m_rsp_q   = gold[REQ_A];
                end else if (REQ_WEM == '0) begin
                    m_rsp_vld = 1'b0;
                end else if (FAST && (&REQ_WEM)) begin
                    gold[REQ_A] = REQ_D;
                end else begin
                    m_merge = 1'b1;
                    m_ready = 1'b0;
                    m_a     = REQ_A;
                    m_d     = REQ_D;
                    m_wem   = REQ_WEM;
                end
            end
        end
    end

    // Compare process: every cycle, mid-period.
    always @(negedge CLK) begin
        if (!RSTN) begin
            check("rst_mem_ce", DW'(MEM_CE), DW'(1'b0));
            check("rst_mem_we", DW'(MEM_WE), DW'(1'b0));
            check("rst_rsp_valid", DW'(RSP_VALID), DW'(1'b0));
        end else begin
            check("req_ready", DW'(REQ_READY), DW'(m_ready));
            check("rsp_valid", DW'(RSP_VALID), DW'(m_rsp_vld));
            if (m_rsp_vld) check("rsp_q", RSP_Q, m_rsp_q);
            if (m_merge) begin
                check("merge_ce", DW'(MEM_CE), DW'(1'b1));
                check("merge_we", DW'(MEM_WE), DW'(1'b1));
                check("merge_a", DW'(MEM_A), DW'(m_a));
                check("merge_d", MEM_D, (gold[m_a] & ~m_wem) | (m_d & m_wem));
            end else if (!REQ_VALID) begin
                check("idle_ce", DW'(MEM_CE), DW'(1'b0));
                check("idle_we", DW'(MEM_WE), DW'(1'b0));
            end else if (!REQ_WE) begin
                check("rd_ce", DW'(MEM_CE), DW'(1'b1));
                check("rd_we", DW'(MEM_WE), DW'(1'b0));
                check("rd_a", DW'(MEM_A), DW'(REQ_A));
            end else if (REQ_WEM == '0) begin
                check("wz_ce", DW'(MEM_CE), DW'(1'b0));
                check("wz_we", DW'(MEM_WE), DW'(1'b0));
            end else if (FAST && (&REQ_WEM)) begin
                check("wf_ce", DW'(MEM_CE), DW'(1'b1));
                check("wf_we", DW'(MEM_WE), DW'(1'b1));
                check("wf_a", DW'(MEM_A), DW'(REQ_A));
                check("wf_d", MEM_D, REQ_D);
            end else begin
                check("rmw_rd_ce", DW'(MEM_CE), DW'(1'b1));
                check("rmw_rd_we", DW'(MEM_WE), DW'(1'b0));
                check("rmw_rd_a", DW'(MEM_A), DW'(REQ_A));
            end
        end
    end

    // Event monitors used by the directed literal checks.
    int            we_cnt = 0;
    int            ce_cnt = 0;
    int            rdy_low = 0;
    logic [DW-1:0] last_wd = '0;
    logic [DW-1:0] last_rsp = '0;
    always @(posedge CLK) begin
        if (MEM_CE) ce_cnt++;
        if (MEM_CE && MEM_WE) begin
            we_cnt++;
            last_wd = MEM_D;
        end
    end
    always @(negedge CLK) begin
        if (RSTN && !REQ_READY) rdy_low++;
        if (RSP_VALID) last_rsp = RSP_Q;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_req(input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] wem);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        REQ_VALID = 1'b1;
        REQ_WE    = we;
        REQ_A     = a;
        REQ_D     = d;
        REQ_WEM   = wem;
        while (!done && n < 10) begin
            @(posedge CLK);
            if (REQ_READY) done = 1'b1;
            n++;
        end
        #1;
        REQ_VALID = 1'b0;
        check("req_accept", DW'(done), DW'(1'b1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            rl;
        int            wc;
        int            cc;
        logic [DW-1:0] wem;
        for (int i = 0; i < DEPTH; i++) begin
            bmem[i] = $urandom;
            gold[i] = bmem[i];
        end
        bmem[3] = 32'hA5A5A5A5; gold[3] = 32'hA5A5A5A5;
        bmem[5] = 32'hFFFF0000; gold[5] = 32'hFFFF0000;
        bmem[7] = 32'h00000000; gold[7] = 32'h00000000;
        bmem[9] = 32'h0BADF00D; gold[9] = 32'h0BADF00D;

        RSTN = 1'b0;
        idle(3);
        RSTN = 1'b1;
        idle(1);
        check("ready_after_reset", DW'(REQ_READY), DW'(1'b1));

        // Preloaded read.
        do_req(1'b0, 9'd5, '0, '0);
        idle(2);
        check("read5_pre", last_rsp, 32'hFFFF0000);

        // Partial write merges the low half.
        rl = rdy_low; wc = we_cnt;
        do_req(1'b1, 9'd5, 32'h12345678, 32'h0000FFFF);
        idle(2);
        check("pw5_ready_low_cycles", DW'(rdy_low - rl), 32'd1);
        check("pw5_we_pulses", DW'(we_cnt - wc), 32'd1);
        check("pw5_mem_d", last_wd, 32'hFFFF5678);
        do_req(1'b0, 9'd5, '0, '0);
        idle(2);
        check("read5_post", last_rsp, 32'hFFFF5678);

        // All-ones mask.
        rl = rdy_low;
        do_req(1'b1, 9'd7, 32'hCAFEBABE, 32'hFFFFFFFF);
        idle(2);
        check("fw7_ready_low_cycles", DW'(rdy_low - rl), FAST ? 32'd0 : 32'd1);
        check("fw7_mem_d", last_wd, 32'hCAFEBABE);
        do_req(1'b0, 9'd7, '0, '0);
        idle(2);
        check("read7", last_rsp, 32'hCAFEBABE);

        // Zero mask is a no-op.
        cc = ce_cnt;
        do_req(1'b1, 9'd9, 32'h11111111, 32'h00000000);
        idle(2);
        check("zw9_ce_count", DW'(ce_cnt - cc), 32'd0);
        do_req(1'b0, 9'd9, '0, '0);
        idle(2);
        check("read9", last_rsp, 32'h0BADF00D);

        // Partial write immediately followed by a read of the same word.
        do_req(1'b1, 9'd3, 32'h0000FFFF, 32'h00FF00FF);
        do_req(1'b0, 9'd3, '0, '0);
        idle(2);
        check("read3_merged", last_rsp, 32'hA500A5FF);

        // Reset while the merge write is pending.
        wc = we_cnt;
        do_req(1'b1, 9'd3, 32'hFFFFFFFF, 32'h0000FF00);
        RSTN = 1'b0;
        check("rst_merge_rsp_valid", DW'(RSP_VALID), DW'(1'b0));
        idle(2);
        check("rst_merge_we_pulses", DW'(we_cnt - wc), 32'd0);
        RSTN = 1'b1;
        idle(1);
        do_req(1'b0, 9'd3, '0, '0);
        idle(2);
        check("read3_after_abort", last_rsp, 32'hA500A5FF);

        // Randomized traffic over a small address window to force collisions.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       wem = '0;
                1:       wem = '1;
                default: wem = $urandom;
            endcase
            REQ_VALID = ($urandom_range(0, 3) != 0);
            REQ_WE    = 1'($urandom_range(0, 1));
            REQ_A     = AW'($urandom_range(0, 15));
            REQ_D     = $urandom;
            REQ_WEM   = wem;
            @(posedge CLK);
            #1;
        end
        REQ_VALID = 1'b0;
        idle(4);

        for (int i = 0; i < DEPTH; i++) check("mem_final", bmem[i], gold[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
